// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one request at a time in
// flight to instruction memory, and buffers returned words together with their
// PC in a small prefetch queue that the decode stage drains.
//
// Handshakes:
//   im_REQ/im_ACK : im_REQ and im_ADDR are held steady until the edge where
//                   im_ACK=1. That edge completes the request. im_ACK while
//                   im_REQ=0 has no effect.
//   if_VALID/id_READY : the head entry transfers on an edge where both are 1.
//                   The head fields read as zero whenever if_VALID=0.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        im_REQ,
  output logic [31:0] im_ADDR,
  input  logic        im_ACK,
  input  logic [31:0] im_RDATA,
  input  logic        br_TAKEN,
  input  logic [31:0] br_TARGET,
  output logic        if_VALID,
  input  logic        id_READY,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];

  logic ack;
  logic push;
  logic pop;
  logic busy_next;

  // A completed request only lands in the queue when it was not issued before
  // a redirect and no redirect is happening right now.
  assign ack       = req_q & im_ACK;
  assign push      = ack & ~discard_q & ~br_TAKEN;
  assign pop       = if_VALID & id_READY & ~br_TAKEN;
  assign busy_next = req_q & ~ack;

  // Next-state: queue bookkeeping, PC advance, redirect flush and issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (br_TAKEN) begin
      fetch_pc_d = br_TARGET;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        wr_ptr_d   = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // A redirect cannot abort a held request, so its eventual data is marked
    // for dropping. One flag covers any number of redirects before the ACK.
    if (ack) begin
      discard_d = 1'b0;
    end else if (br_TAKEN && req_q) begin
      discard_d = 1'b1;
    end

    if (ack) begin
      req_d = 1'b0;
    end
    // The new request is charged against free space up front, so the queue
    // always has a slot for whatever comes back.
    if (!busy_next && !br_TAKEN && (count_d < DEPTH_C)) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Prefetch queue storage; entries are qualified by count_q, so no reset.
  always_ff @(posedge CLK) begin
    if (!RESET && push) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
      ins_mem_q[wr_ptr_q] <= im_RDATA;
    end
  end

  // Design-error guard: a push must never land on a full queue.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      assert (!(push && (count_q == DEPTH_C)));
    end
  end

  assign im_REQ         = req_q;
  assign im_ADDR        = addr_q;
  assign if_VALID       = (count_q != '0);
  assign if_pc          = if_VALID ? pc_mem_q[rd_ptr_q]  : 32'h0;
  assign if_instruction = if_VALID ? ins_mem_q[rd_ptr_q] : 32'h0;

endmodule
